process_sequencer: RTL and testbench

Parametrised frame/block sequencer for the MEMC datapath and the successor to the fixed 1–9 frame / 48-block controller. It generates frame completion internally from the block count rather than taking an external `frame_done`. It adds 2-D block coordinates, a start/busy/done handshake, synchronous abort and an optional loop mode. It sits between the top-level control and the ME/MC engines, which consume `block_id`/`block_x`/`block_y`/`frame_id` and return `block_done`.

---
 rtl/memc_pkg.sv | 20 ++
 rtl/process_sequencer_if.sv | 37 +++
 rtl/process_sequencer_wrap_counter.sv | 31 +++
 rtl/process_sequencer.sv | 140 ++++++++++++++
 tb/tb_process_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/memc_pkg.sv
// Shared MEMC definitions: sequencer state type, default frame/block geometry
// and a width helper for narrow counters.
package memc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int MEMC_BLOCKS_X    = 8;
    localparam int MEMC_BLOCKS_Y    = 6;
    localparam int MEMC_FIRST_FRAME = 1;
    localparam int MEMC_LAST_FRAME  = 9;

    // Counter width that never collapses to zero bits for counts of 1 or 2
    function automatic int clogMin1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/process_sequencer_if.sv
// Control/engine-facing bundle of the frame/block sequencer: start/abort and
// block_done in, block coordinates, frame index and status pulses out.
interface process_sequencer_if
    import memc_pkg::*;
#(
    parameter int FRAME_W = $clog2(MEMC_LAST_FRAME + 1),
    parameter int BLOCK_W = clogMin1(MEMC_BLOCKS_X * MEMC_BLOCKS_Y),
    parameter int BX_W    = clogMin1(MEMC_BLOCKS_X),
    parameter int BY_W    = clogMin1(MEMC_BLOCKS_Y)
) ();

    logic               start;
    logic               abort;
    logic               block_done;
    logic [FRAME_W-1:0] frame_id;
    logic [BLOCK_W-1:0] block_id;
    logic [BX_W-1:0]    block_x;
    logic [BY_W-1:0]    block_y;
    logic               block_start;
    logic               frame_inc;
    logic               frame_wrap;
    logic               busy;
    logic               seq_done;

    modport master (
        output start, abort, block_done,
        input  frame_id, block_id, block_x, block_y,
        input  block_start, frame_inc, frame_wrap, busy, seq_done
    );

    modport slave (
        input  start, abort, block_done,
        output frame_id, block_id, block_x, block_y,
        output block_start, frame_inc, frame_wrap, busy, seq_done
    );

endinterface

// File: rtl/process_sequencer_wrap_counter.sv
// Bounded up-counter running MIN..MAX and wrapping back to MIN; clr has
// priority over inc and at_max flags the terminal count.
module wrap_counter #(
    parameter int WIDTH = 4,
    parameter int MIN   = 0,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= WIDTH'(MIN);
        end else if (clr) begin
            r_value <= WIDTH'(MIN);
        end else if (inc) begin
            r_value <= (r_value == WIDTH'(MAX)) ? WIDTH'(MIN) : r_value + WIDTH'(1);
        end
    end

    assign value  = r_value;
    assign at_max = (r_value == WIDTH'(MAX));

endmodule

// File: rtl/process_sequencer.sv
// MEMC frame/block sequencer: walks blocks in raster order across frames,
// deriving frame completion from the block count, with abort and optional looping.
module process_sequencer
    import memc_pkg::*;
#(
    parameter int FIRST_FRAME = MEMC_FIRST_FRAME,
    parameter int LAST_FRAME  = MEMC_LAST_FRAME,
    parameter int BLOCKS_X    = MEMC_BLOCKS_X,
    parameter int BLOCKS_Y    = MEMC_BLOCKS_Y,
    parameter int LOOP        = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    process_sequencer_if.slave   seq_if
);

    localparam int BLOCKS  = BLOCKS_X * BLOCKS_Y;
    localparam int FRAME_W = $clog2(LAST_FRAME + 1);
    localparam int BLOCK_W = clogMin1(BLOCKS);
    localparam int BX_W    = clogMin1(BLOCKS_X);
    localparam int BY_W    = clogMin1(BLOCKS_Y);

    seq_state_t         r_state;
    logic [BLOCK_W-1:0] r_blockId;
    logic               r_blockStart;
    logic               r_frameInc;
    logic               r_frameWrap;
    logic               r_busy;
    logic               r_seqDone;

    logic [BX_W-1:0]    w_x;
    logic [BY_W-1:0]    w_y;
    logic [FRAME_W-1:0] w_frame;
    logic               w_xAtMax;
    logic               w_yAtMax;
    logic               w_frameAtMax;
    logic               w_accept;
    logic               w_lastBlock;
    logic               w_seqEnd;
    logic               w_clr;

    // Carry chain: x ticks on every accepted block, y on x wrap, frame on last block
    assign w_accept    = (r_state == RUN) && seq_if.block_done && !seq_if.abort;
    assign w_lastBlock = w_xAtMax && w_yAtMax;
    assign w_seqEnd    = w_accept && w_lastBlock && w_frameAtMax && (LOOP == 0);
    assign w_clr       = seq_if.abort || w_seqEnd;

    wrap_counter #(.WIDTH(BX_W), .MIN(0), .MAX(BLOCKS_X - 1)) u_xCounter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_accept),
        .value  (w_x),
        .at_max (w_xAtMax)
    );

    wrap_counter #(.WIDTH(BY_W), .MIN(0), .MAX(BLOCKS_Y - 1)) u_yCounter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_accept && w_xAtMax),
        .value  (w_y),
        .at_max (w_yAtMax)
    );

    wrap_counter #(.WIDTH(FRAME_W), .MIN(FIRST_FRAME), .MAX(LAST_FRAME)) u_frameCounter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_accept && w_lastBlock),
        .value  (w_frame),
        .at_max (w_frameAtMax)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_blockId    <= '0;
            r_blockStart <= 1'b0;
            r_frameInc   <= 1'b0;
            r_frameWrap  <= 1'b0;
            r_busy       <= 1'b0;
            r_seqDone    <= 1'b0;
        end else begin
            r_blockStart <= 1'b0;
            r_frameInc   <= 1'b0;
            r_frameWrap  <= 1'b0;
            r_seqDone    <= 1'b0;
            if (seq_if.abort) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_blockId <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (seq_if.start) begin
                            r_state      <= RUN;
                            r_busy       <= 1'b1;
                            r_blockStart <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (seq_if.block_done) begin
                            if (!w_lastBlock) begin
                                r_blockId    <= r_blockId + BLOCK_W'(1);
                                r_blockStart <= 1'b1;
                            end else if (!w_frameAtMax || (LOOP != 0)) begin
                                r_blockId    <= '0;
                                r_blockStart <= 1'b1;
                                r_frameInc   <= 1'b1;
                                r_frameWrap  <= w_frameAtMax;
                            end else begin
                                r_state   <= IDLE;
                                r_busy    <= 1'b0;
                                r_seqDone <= 1'b1;
                                r_blockId <= '0;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign seq_if.frame_id    = w_frame;
    assign seq_if.block_id    = r_blockId;
    assign seq_if.block_x     = w_x;
    assign seq_if.block_y     = w_y;
    assign seq_if.block_start = r_blockStart;
    assign seq_if.frame_inc   = r_frameInc;
    assign seq_if.frame_wrap  = r_frameWrap;
    assign seq_if.busy        = r_busy;
    assign seq_if.seq_done    = r_seqDone;

    // The linear id is counted separately from x/y, so tie the two views together
    assert property (@(posedge clk) disable iff (!rst_n)
        32'(r_blockId) == 32'(w_y) * 32'(BLOCKS_X) + 32'(w_x));

endmodule

// File: tb/tb_process_sequencer.sv
// Scoreboard bench for process_sequencer: a default-geometry instance and a
// small looping instance share one directed stimulus stream.
module tb_process_sequencer;
    import memc_pkg::*;

    typedef struct packed {
        logic [7:0] frame;
        logic [7:0] blk;
        logic [7:0] x;
        logic [7:0] y;
        logic       bs;
        logic       inc;
        logic       wrap;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk;
    logic rst_n;

    process_sequencer_if #(.FRAME_W(4), .BLOCK_W(6), .BX_W(3), .BY_W(3)) bus0 ();
    process_sequencer_if #(.FRAME_W(2), .BLOCK_W(1), .BX_W(1), .BY_W(1)) bus1 ();

    process_sequencer dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus0)
    );

    process_sequencer #(
        .FIRST_FRAME (1),
        .LAST_FRAME  (2),
        .BLOCKS_X    (2),
        .BLOCKS_Y    (1),
        .LOOP        (1)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t q0[$];
    obs_t q1[$];
    int   testsRun;
    int   failCount;
    int   bsCount;
    int   incCount;
    int   doneCount;
    int   mFrame[2];
    int   mBlk[2];
    bit   mRun[2];

    function automatic int cBx(int k);    return (k == 0) ? MEMC_BLOCKS_X : 2; endfunction
    function automatic int cBy(int k);    return (k == 0) ? MEMC_BLOCKS_Y : 1; endfunction
    function automatic int cFirst(int k); return (k == 0) ? MEMC_FIRST_FRAME : 1; endfunction
    function automatic int cLast(int k);  return (k == 0) ? MEMC_LAST_FRAME : 2; endfunction
    function automatic bit cLoop(int k);  return (k != 0); endfunction

    function automatic obs_t mkObs(int f, int b, int x, int y,
                                   logic bs, logic inc, logic wrap, logic busy, logic done);
        obs_t o;
        o.frame = 8'(f);
        o.blk   = 8'(b);
        o.x     = 8'(x);
        o.y     = 8'(y);
        o.bs    = bs;
        o.inc   = inc;
        o.wrap  = wrap;
        o.busy  = busy;
        o.done  = done;
        return o;
    endfunction

    function automatic obs_t getObs0();
        return mkObs(int'(bus0.frame_id), int'(bus0.block_id), int'(bus0.block_x),
                     int'(bus0.block_y), bus0.block_start, bus0.frame_inc,
                     bus0.frame_wrap, bus0.busy, bus0.seq_done);
    endfunction

    function automatic obs_t getObs1();
        return mkObs(int'(bus1.frame_id), int'(bus1.block_id), int'(bus1.block_x),
                     int'(bus1.block_y), bus1.block_start, bus1.frame_inc,
                     bus1.frame_wrap, bus1.busy, bus1.seq_done);
    endfunction

    function automatic obs_t modelReset(int k);
        mFrame[k] = cFirst(k);
        mBlk[k]   = 0;
        mRun[k]   = 1'b0;
        return mkObs(cFirst(k), 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Reference behaviour; coordinates derived from the linear index by div/mod
    function automatic obs_t modelStep(int k, logic s, logic a, logic d);
        logic bs, inc, wrap, done;
        bs = 1'b0; inc = 1'b0; wrap = 1'b0; done = 1'b0;
        if (a) begin
            mRun[k] = 1'b0; mFrame[k] = cFirst(k); mBlk[k] = 0;
        end else if (!mRun[k]) begin
            if (s) begin mRun[k] = 1'b1; bs = 1'b1; end
        end else if (d) begin
            if (mBlk[k] < cBx(k) * cBy(k) - 1) begin
                mBlk[k]++; bs = 1'b1;
            end else if (mFrame[k] < cLast(k)) begin
                mFrame[k]++; mBlk[k] = 0; bs = 1'b1; inc = 1'b1;
            end else if (cLoop(k)) begin
                mFrame[k] = cFirst(k); mBlk[k] = 0; bs = 1'b1; inc = 1'b1; wrap = 1'b1;
            end else begin
                mRun[k] = 1'b0; mFrame[k] = cFirst(k); mBlk[k] = 0; done = 1'b1;
            end
        end
        return mkObs(mFrame[k], mBlk[k], mBlk[k] % cBx(k), mBlk[k] / cBx(k),
                     bs, inc, wrap, mRun[k], done);
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        obs_t e0, e1, o0;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        o0 = getObs0();
        checkVal("dut0 outputs", o0, e0);
        checkVal("dut1 outputs", getObs1(), e1);
        bsCount   += int'(o0.bs);
        incCount  += int'(o0.inc);
        doneCount += int'(o0.done);
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic d);
        bus0.start = s; bus0.abort = a; bus0.block_done = d;
        bus1.start = s; bus1.abort = a; bus1.block_done = d;
        q0.push_back(modelStep(0, s, a, d));
        q1.push_back(modelStep(1, s, a, d));
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic holdReset(input int n);
        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.block_done = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.block_done = 1'b0;
        repeat (n) begin
            q0.push_back(modelReset(0));
            q1.push_back(modelReset(1));
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        testsRun = 0; failCount = 0;
        bsCount = 0; incCount = 0; doneCount = 0;
        rst_n = 1'b0;
        #2;
        holdReset(3);
        checkVal("reset state", getObs0(), mkObs(1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // block_done while idle, then start, then start again while running
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        bsCount = 0; incCount = 0; doneCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("first block", getObs0(), mkObs(1, 0, 0, 0, 1, 0, 0, 1, 0));
        applyStimulus(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 432; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (i == 3)   checkVal("loop wrap",   getObs1(), mkObs(1, 0, 0, 0, 1, 1, 1, 1, 0));
            if (i == 7)   checkVal("row carry",   getObs0(), mkObs(1, 8, 0, 1, 1, 0, 0, 1, 0));
            if (i == 47)  checkVal("frame carry", getObs0(), mkObs(2, 0, 0, 0, 1, 1, 0, 1, 0));
            if (i == 430) checkVal("last block",  getObs0(), mkObs(9, 47, 7, 5, 1, 0, 0, 1, 0));
            if (i == 431) checkVal("seq done",    getObs0(), mkObs(1, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        checkVal("block_start count", bsCount, 432);
        checkVal("frame_inc count", incCount, 8);
        checkVal("seq_done count", doneCount, 1);
        checkVal("loop busy", bus1.busy, 1);

        // Restart right after seq_done, then abort together with block_done
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("restart", getObs0(), mkObs(1, 0, 0, 0, 1, 0, 0, 1, 0));
        repeat (116) applyStimulus(1'b0, 1'b0, 1'b1);
        checkVal("frame3 block20", getObs0(), mkObs(3, 20, 4, 2, 1, 0, 0, 1, 0));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkVal("abort", getObs0(), mkObs(1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkVal("abort with start", getObs0(), mkObs(1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset between clock edges mid-frame
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkVal("async reset", getObs0(), mkObs(1, 0, 0, 0, 0, 0, 0, 0, 0));
        checkVal("async reset loop", getObs1(), mkObs(1, 0, 0, 0, 0, 0, 0, 0, 0));
        holdReset(1);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("start after reset", getObs0(), mkObs(1, 0, 0, 0, 1, 0, 0, 1, 0));
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
